// File: rtl/uart_apb_pkg.sv
// ============================================================================
// Module : uart_apb_pkg
// Brief  : Register map, status bit indices and state encodings shared by the
//          UART APB initiator and its APB phase engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_apb_pkg;

    localparam logic [4:0] ADDR_TXD  = 5'h00;
    localparam logic [4:0] ADDR_RXD  = 5'h04;
    localparam logic [4:0] ADDR_CR1  = 5'h08;
    localparam logic [4:0] ADDR_CR2  = 5'h0C;
    localparam logic [4:0] ADDR_STAT = 5'h10;
    localparam logic [4:0] ADDR_RSVD = 5'h14;

    localparam int STAT_TXRDY    = 0;
    localparam int STAT_RXRDY    = 1;
    localparam int STAT_PARITY   = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_FRAMING  = 4;

    typedef enum logic [2:0] {
        ST_INIT_CR1 = 3'd0,
        ST_INIT_CR2 = 3'd1,
        ST_POLL     = 3'd2,
        ST_RD_RX    = 3'd3,
        ST_WR_TX    = 3'd4,
        ST_GAP      = 3'd5
    } cmd_state_t;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } xfer_phase_t;

endpackage

`default_nettype wire

// File: rtl/uart_apb_xfer.sv
// ============================================================================
// Module : uart_apb_xfer
// Brief  : APB phase engine: setup, access with wait states, response capture
//          and a one-cycle done strobe in the idle cycle after completion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_apb_xfer
    import uart_apb_pkg::*;
(
    input  logic       PCLK,
    input  logic       aresetn,
    input  logic       start_i,
    input  logic [4:0] addr_i,
    input  logic       write_i,
    input  logic [7:0] wdata_i,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       slverr_o
);

    xfer_phase_t phase_q, phase_d;
    logic [4:0]  addr_q;
    logic        write_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        slverr_q;
    logic        done_q;
    logic        complete;

    assign complete = (phase_q == PH_ACCESS) && PREADY;

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE:   if (start_i) phase_d = PH_SETUP;
            PH_SETUP:  phase_d = PH_ACCESS;
            PH_ACCESS: if (PREADY) phase_d = PH_IDLE;
            default:   phase_d = PH_IDLE;
        endcase
    end

    // Address/control/data latch once at launch and stay put until the next launch.
    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            phase_q  <= PH_IDLE;
            addr_q   <= 5'd0;
            write_q  <= 1'b0;
            wdata_q  <= 8'd0;
            rdata_q  <= 8'd0;
            slverr_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            done_q  <= complete;
            if ((phase_q == PH_IDLE) && start_i) begin
                addr_q  <= addr_i;
                write_q <= write_i;
                wdata_q <= wdata_i;
            end
            if (complete) begin
                rdata_q  <= PRDATA;
                slverr_q <= PSLVERR;
            end
        end
    end

    assign PADDR    = addr_q;
    assign PWRITE   = write_q;
    assign PWDATA   = wdata_q;
    assign PSEL     = (phase_q != PH_IDLE);
    assign PENABLE  = (phase_q == PH_ACCESS);
    assign busy_o   = (phase_q != PH_IDLE);
    assign done_o   = done_q;
    assign rdata_o  = rdata_q;
    assign slverr_o = slverr_q;

endmodule

`default_nettype wire

// File: rtl/uart_apb_initiator.sv
// ============================================================================
// Module : uart_apb_initiator
// Brief  : Configures an APB UART, then polls its status and moves bytes
//          between the local tx/rx handshakes and the UART data registers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_apb_initiator
    import uart_apb_pkg::*;
#(
    parameter logic [7:0]  INIT_BAUD  = 8'd26,
    parameter logic [7:0]  INIT_CTRL2 = 8'h01,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic       PCLK,
    input  logic       aresetn,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [3:0] err_flags,
    input  logic       err_clr,
    output logic       init_done
);

    localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);

    cmd_state_t state_q, state_d;
    cmd_state_t ret_q, ret_d;
    logic [7:0] gap_q, gap_d;
    logic       launched_q, launched_d;
    logic       armed_q;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [3:0] err_q, err_d, err_set;
    logic       init_done_q, init_done_d;

    logic       x_start;
    logic [4:0] x_addr;
    logic       x_write;
    logic [7:0] x_wdata;
    logic       x_busy;
    logic       x_done;
    logic [7:0] x_rdata;
    logic       x_slverr;

    uart_apb_xfer u_xfer (
        .PCLK     (PCLK),
        .aresetn  (aresetn),
        .start_i  (x_start),
        .addr_i   (x_addr),
        .write_i  (x_write),
        .wdata_i  (x_wdata),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .busy_o   (x_busy),
        .done_o   (x_done),
        .rdata_o  (x_rdata),
        .slverr_o (x_slverr)
    );

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        gap_d       = gap_q;
        launched_d  = launched_q;
        rx_valid_d  = rx_valid_q && !rx_ready;
        rx_data_d   = rx_data_q;
        init_done_d = init_done_q;
        err_set     = 4'b0000;
        x_start     = 1'b0;

        if (x_done) begin
            launched_d = 1'b0;
            err_set[3] = x_slverr;
            case (state_q)
                ST_INIT_CR1: begin
                    if (x_slverr) begin
                        ret_d   = ST_INIT_CR1;
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_INIT_CR2;
                    end
                end
                ST_INIT_CR2: begin
                    if (x_slverr) begin
                        ret_d   = ST_INIT_CR2;
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = ST_POLL;
                    end
                end
                ST_POLL: begin
                    // An errored status read carries no trustworthy bits; just back off.
                    if (!x_slverr) begin
                        err_set[0] = x_rdata[STAT_PARITY];
                        err_set[1] = x_rdata[STAT_OVERFLOW];
                        err_set[2] = x_rdata[STAT_FRAMING];
                    end
                    if (!x_slverr && x_rdata[STAT_RXRDY] && !rx_valid_q) begin
                        state_d = ST_RD_RX;
                    end else if (!x_slverr && x_rdata[STAT_TXRDY] && tx_valid) begin
                        state_d = ST_WR_TX;
                    end else begin
                        ret_d   = ST_POLL;
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end
                ST_RD_RX: begin
                    if (!x_slverr) begin
                        rx_data_d  = x_rdata;
                        rx_valid_d = 1'b1;
                    end
                    state_d = ST_POLL;
                end
                ST_WR_TX: state_d = ST_POLL;
                default:  state_d = ST_POLL;
            endcase
        end else if (state_q == ST_GAP) begin
            if (gap_q == 8'd0) begin
                state_d = ret_q;
            end else begin
                gap_d = gap_q - 8'd1;
            end
        end

        // Launch in the same cycle the next state is chosen so the bus idles exactly one cycle.
        if (armed_q && !x_busy && !launched_d && (state_d != ST_GAP)) begin
            x_start    = 1'b1;
            launched_d = 1'b1;
        end

        x_addr  = 5'd0;
        x_write = 1'b0;
        x_wdata = 8'd0;
        case (state_d)
            ST_INIT_CR1: begin x_addr = ADDR_CR1;  x_write = 1'b1; x_wdata = INIT_BAUD;  end
            ST_INIT_CR2: begin x_addr = ADDR_CR2;  x_write = 1'b1; x_wdata = INIT_CTRL2; end
            ST_POLL:     begin x_addr = ADDR_STAT; end
            ST_RD_RX:    begin x_addr = ADDR_RXD;  end
            ST_WR_TX:    begin x_addr = ADDR_TXD;  x_write = 1'b1; x_wdata = tx_data;    end
            default:     begin x_addr = 5'd0;      end
        endcase

        // Newly detected errors win over a simultaneous clear.
        err_d = (err_clr ? 4'b0000 : err_q) | err_set;
    end

    always_ff @(posedge PCLK or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_INIT_CR1;
            ret_q       <= ST_INIT_CR1;
            gap_q       <= 8'd0;
            launched_q  <= 1'b0;
            armed_q     <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'd0;
            err_q       <= 4'b0000;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            gap_q       <= gap_d;
            launched_q  <= launched_d;
            armed_q     <= 1'b1;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            err_q       <= err_d;
            init_done_q <= init_done_d;
        end
    end

    assign tx_ready  = x_done && (state_q == ST_WR_TX);
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign err_flags = err_q;
    assign init_done = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_apb_initiator.sv
// ============================================================================
// Module : tb_uart_apb_initiator
// Brief  : Directed table-driven bench with an APB responder task and a few
//          hand-written sequences for error clear, reset and init retry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_apb_initiator;

    logic       PCLK = 1'b0;
    logic       aresetn;
    logic [4:0] PADDR;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [3:0] err_flags;
    logic       err_clr;
    logic       init_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 PCLK = ~PCLK;

    uart_apb_initiator dut (
        .PCLK      (PCLK),
        .aresetn   (aresetn),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .err_flags (err_flags),
        .err_clr   (err_clr),
        .init_done (init_done)
    );

    typedef struct {
        logic [4:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         waits;
        logic       err;
        logic       txv;
        logic [7:0] txd;
        logic       rxr;
        logic       exp_txr;
        logic       exp_rxv;
        logic [7:0] exp_rxd;
        logic [3:0] exp_err;
        logic       exp_init;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Act as the UART responder for one transfer; returns at the negedge after completion.
    task automatic serve(input logic [4:0] a, input logic w, input logic [7:0] wd,
                         input logic [7:0] rd, input int waits, input logic err, input string nm);
        int n = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
        while (!(PSEL && !PENABLE) && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 200) begin
            check({nm, " setup timeout"}, 32'd0, 32'd1);
            return;
        end
        check({nm, " PADDR"}, {27'd0, PADDR}, {27'd0, a});
        check({nm, " PWRITE"}, {31'd0, PWRITE}, {31'd0, w});
        if (w) check({nm, " PWDATA"}, {24'd0, PWDATA}, {24'd0, wd});
        @(negedge PCLK);
        check({nm, " access"}, {30'd0, PSEL, PENABLE}, 32'd3);
        for (int i = 0; i < waits; i++) begin
            @(negedge PCLK);
            check({nm, " wait hold"}, {16'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA},
                  {16'd0, 1'b1, 1'b1, w, a, (w ? wd : PWDATA)});
        end
        PREADY = 1'b1; PRDATA = rd; PSLVERR = err;
        @(negedge PCLK);
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;
        check({nm, " idle after"}, {31'd0, PSEL}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; PRDATA = 8'h00; PREADY = 1'b0; PSLVERR = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; err_clr = 1'b0;

        //            addr   wr    wdata  rdata  wt err   txv   txd    rxr   txr   rxv   rxd    err    init
        vecs[0]  = '{5'h08, 1'b1, 8'h1A, 8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0};
        vecs[1]  = '{5'h0C, 1'b1, 8'h01, 8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1};
        vecs[2]  = '{5'h10, 1'b0, 8'h00, 8'h02, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1};
        vecs[3]  = '{5'h04, 1'b0, 8'h00, 8'hA5, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 4'h0, 1'b1};
        vecs[4]  = '{5'h10, 1'b0, 8'h00, 8'h02, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 4'h0, 1'b1};
        vecs[5]  = '{5'h10, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 4'h0, 1'b1};
        vecs[6]  = '{5'h10, 1'b0, 8'h00, 8'h01, 0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 4'h0, 1'b1};
        vecs[7]  = '{5'h00, 1'b1, 8'h3C, 8'h00, 3, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hA5, 4'h0, 1'b1};
        vecs[8]  = '{5'h10, 1'b0, 8'h00, 8'h1C, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 4'h7, 1'b1};
        vecs[9]  = '{5'h10, 1'b0, 8'h00, 8'h02, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 4'h7, 1'b1};
        vecs[10] = '{5'h04, 1'b0, 8'h00, 8'hEE, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 4'hF, 1'b1};
        vecs[11] = '{5'h10, 1'b0, 8'h00, 8'h03, 0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'hA5, 4'hF, 1'b1};
        vecs[12] = '{5'h04, 1'b0, 8'h00, 8'h77, 0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h77, 4'hF, 1'b1};
        vecs[13] = '{5'h10, 1'b0, 8'h00, 8'h03, 0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h77, 4'hF, 1'b1};
        vecs[14] = '{5'h00, 1'b1, 8'h5A, 8'h00, 0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h77, 4'hF, 1'b1};
        vecs[15] = '{5'h10, 1'b0, 8'h00, 8'h01, 0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'h77, 4'hF, 1'b1};
        vecs[16] = '{5'h00, 1'b1, 8'hC3, 8'h00, 2, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h77, 4'hF, 1'b1};

        repeat (3) @(negedge PCLK);
        check("reset bus", {16'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 32'd0);
        check("reset local", {16'd0, tx_ready, rx_valid, rx_data, err_flags, init_done, 1'b0},
              32'd0);

        aresetn = 1'b1;
        @(negedge PCLK);
        check("first edge idle", {31'd0, PSEL}, 32'd0);
        @(negedge PCLK);
        check("second edge setup", {30'd0, PSEL, PENABLE}, 32'd2);

        for (int k = 0; k < 17; k++) begin
            tx_valid = vecs[k].txv;
            tx_data  = vecs[k].txd;
            rx_ready = vecs[k].rxr;
            serve(vecs[k].addr, vecs[k].wr, vecs[k].wdata, vecs[k].rdata,
                  vecs[k].waits, vecs[k].err, $sformatf("v%0d", k));
            check($sformatf("v%0d tx_ready", k), {31'd0, tx_ready}, {31'd0, vecs[k].exp_txr});
            @(negedge PCLK);
            check($sformatf("v%0d tx_ready one-shot", k), {31'd0, tx_ready}, 32'd0);
            check($sformatf("v%0d rx_valid", k), {31'd0, rx_valid}, {31'd0, vecs[k].exp_rxv});
            check($sformatf("v%0d rx_data", k), {24'd0, rx_data}, {24'd0, vecs[k].exp_rxd});
            check($sformatf("v%0d err_flags", k), {28'd0, err_flags}, {28'd0, vecs[k].exp_err});
            check($sformatf("v%0d init_done", k), {31'd0, init_done}, {31'd0, vecs[k].exp_init});
        end

        // Clear coinciding with a fresh parity error: only the new bit survives.
        tx_valid = 1'b0;
        serve(5'h10, 1'b0, 8'h00, 8'h04, 0, 1'b0, "clr poll");
        err_clr = 1'b1;
        @(negedge PCLK);
        err_clr = 1'b0;
        check("clr vs set", {28'd0, err_flags}, 32'd1);

        // Reset during the access phase of the next poll.
        begin
            int n = 0;
            while (!(PSEL && !PENABLE) && n < 200) begin
                @(negedge PCLK);
                n++;
            end
            check("reset poll found", {31'd0, (n < 200)}, 32'd1);
        end
        @(negedge PCLK);
        check("pre-reset access", {30'd0, PSEL, PENABLE}, 32'd3);
        #2 aresetn = 1'b0;
        #1;
        check("async reset bus", {30'd0, PSEL, PENABLE}, 32'd0);
        check("async reset state", {18'd0, rx_valid, rx_data, err_flags, init_done}, 32'd0);
        @(negedge PCLK);
        aresetn = 1'b1;

        // Rerun of INIT with an error on the first CR1 write: retried after a gap.
        serve(5'h08, 1'b1, 8'h1A, 8'h00, 0, 1'b1, "cr1 err");
        @(negedge PCLK);
        check("cr1 err flag", {28'd0, err_flags}, 32'd8);
        check("cr1 err no init", {31'd0, init_done}, 32'd0);
        serve(5'h08, 1'b1, 8'h1A, 8'h00, 0, 1'b0, "cr1 retry");
        serve(5'h0C, 1'b1, 8'h01, 8'h00, 1, 1'b0, "cr2 rerun");
        @(negedge PCLK);
        check("init rerun done", {31'd0, init_done}, 32'd1);
        serve(5'h10, 1'b0, 8'h00, 8'h00, 0, 1'b0, "poll after rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
